// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 5-stage RV32I core.
// Handles multi-cycle load-use stalls, data-memory freezes and branch
// redirects. It drives every pipeline-register enable and flush.
// Optional feature macro: HAZARD_PERF_CNT_EN adds saturating performance
// counters for stall, flush and busy cycles.
module hazard_ctrl #(
  parameter int REG_ADDR_W   = 5,
  parameter int LOAD_LAT     = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_ex_rd,
  input  logic                  id_ex_mem_read,
  input  logic [REG_ADDR_W-1:0] if_id_rs1,
  input  logic [REG_ADDR_W-1:0] if_id_rs2,
  input  logic                  rs1_used,
  input  logic                  rs2_used,
  input  logic                  pc_sel,
  input  logic                  dmem_busy,
  output logic                  pc_we,
  output logic                  if_id_we,
  output logic                  id_ex_we,
  output logic                  ex_mem_we,
  output logic                  mem_wb_we,
  output logic                  id_ex_bubble,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  stall_active
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      perf_stall_cnt,
  output logic [CNT_W-1:0]      perf_flush_cnt,
  output logic [CNT_W-1:0]      perf_busy_cnt
`endif
);

  // Reject configurations the 3-bit counter or the pipeline cannot honour.
  if (LOAD_LAT < 1 || LOAD_LAT > 7) begin : g_bad_load_lat
    $error("hazard_ctrl: LOAD_LAT=%0d outside 1..7", LOAD_LAT);
  end
  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 4) begin : g_bad_flush_cycles
    $error("hazard_ctrl: FLUSH_CYCLES=%0d outside 1..4", FLUSH_CYCLES);
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("hazard_ctrl: CNT_W=%0d must be at least 1", CNT_W);
  end

  // Counter load values: the first stall or flush cycle is issued from IDLE
  // (or the redirect cycle), so the dedicated states cover the remainder.
  localparam logic [2:0] LD_INIT = 3'(LOAD_LAT - 1);
  localparam logic [2:0] FL_INIT = 3'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    LD_STALL,
    FLUSH
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] cnt;
  logic [2:0] cnt_nxt;
  logic       hazard;

  // A load in EX feeds a register that ID actually reads; x0 never hazards.
  assign hazard = id_ex_mem_read && (id_ex_rd != '0) &&
                  ((rs1_used && (id_ex_rd == if_id_rs1)) ||
                   (rs2_used && (id_ex_rd == if_id_rs2)));

  // State and remaining-cycle counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: busy freezes everything, a redirect aborts any stall.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (dmem_busy) begin
      state_nxt = state;
      cnt_nxt   = cnt;
    end else if (pc_sel) begin
      if (FLUSH_CYCLES > 1) begin
        state_nxt = FLUSH;
        cnt_nxt   = FL_INIT;
      end else begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (hazard && (LOAD_LAT > 1)) begin
            state_nxt = LD_STALL;
            cnt_nxt   = LD_INIT;
          end
        end
        LD_STALL, FLUSH: begin
          if (cnt == 3'd1) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt - 3'd1;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Enables, bubble and flushes decoded by priority: reset, busy, redirect, stall.
  always_comb begin
    pc_we        = 1'b1;
    if_id_we     = 1'b1;
    id_ex_we     = 1'b1;
    ex_mem_we    = 1'b1;
    mem_wb_we    = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    if (!rst_n) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (dmem_busy) begin
      pc_we     = 1'b0;
      if_id_we  = 1'b0;
      id_ex_we  = 1'b0;
      ex_mem_we = 1'b0;
      mem_wb_we = 1'b0;
    end else if (pc_sel) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if ((state == LD_STALL) || ((state == IDLE) && hazard)) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      id_ex_bubble = 1'b1;
    end else if (state == FLUSH) begin
      if_id_flush = 1'b1;
    end
    stall_active = !pc_we;
  end

`ifdef HAZARD_PERF_CNT_EN
  logic stall_cycle;

  // A load-stall cycle is one where a bubble is injected into ID/EX.
  assign stall_cycle = rst_n && id_ex_bubble;

  // Saturating event counters, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
      perf_busy_cnt  <= '0;
    end else begin
      if (stall_cycle && (perf_stall_cnt != '1))
        perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
      if (if_id_flush && (perf_flush_cnt != '1))
        perf_flush_cnt <= perf_flush_cnt + CNT_W'(1);
      if (dmem_busy && (perf_busy_cnt != '1))
        perf_busy_cnt <= perf_busy_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl with LOAD_LAT=3, FLUSH_CYCLES=2: a hand-derived
// vector table for the corner sequences, then randomized traffic against a
// remaining-cycles reference model.
module tb_hazard_ctrl;

  localparam int LL = 3;
  localparam int FC = 2;

  // Output word order: pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
  // id_ex_bubble, if_id_flush, id_ex_flush, stall_active.
  localparam logic [8:0] O_DEF   = 9'b111110000;
  localparam logic [8:0] O_STALL = 9'b001111001;
  localparam logic [8:0] O_BUSY  = 9'b000000001;
  localparam logic [8:0] O_BR    = 9'b111110110;
  localparam logic [8:0] O_FL    = 9'b111110100;
  localparam logic [8:0] O_RST   = 9'b111110110;

  typedef struct {
    logic       rstN;
    logic       memRead;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic       rs1Used;
    logic [4:0] rs2;
    logic       rs2Used;
    logic       pcSel;
    logic       busy;
    logic [8:0] expOut;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_ex_rd;
  logic       id_ex_mem_read;
  logic [4:0] if_id_rs1;
  logic [4:0] if_id_rs2;
  logic       rs1_used;
  logic       rs2_used;
  logic       pc_sel;
  logic       dmem_busy;
  logic       pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
  logic       id_ex_bubble, if_id_flush, id_ex_flush, stall_active;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt, perf_busy_cnt;
`endif
  logic [8:0] outVec;

  int vectors     = 0;
  int miscompares = 0;
  int stallLeft   = 0;
  int flushLeft   = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  hazard_ctrl #(
    .REG_ADDR_W  (5),
    .LOAD_LAT    (LL),
    .FLUSH_CYCLES(FC),
    .CNT_W       (32)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_ex_rd      (id_ex_rd),
    .id_ex_mem_read(id_ex_mem_read),
    .if_id_rs1     (if_id_rs1),
    .if_id_rs2     (if_id_rs2),
    .rs1_used      (rs1_used),
    .rs2_used      (rs2_used),
    .pc_sel        (pc_sel),
    .dmem_busy     (dmem_busy),
    .pc_we         (pc_we),
    .if_id_we      (if_id_we),
    .id_ex_we      (id_ex_we),
    .ex_mem_we     (ex_mem_we),
    .mem_wb_we     (mem_wb_we),
    .id_ex_bubble  (id_ex_bubble),
    .if_id_flush   (if_id_flush),
    .id_ex_flush   (id_ex_flush),
    .stall_active  (stall_active)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .perf_stall_cnt(perf_stall_cnt),
    .perf_flush_cnt(perf_flush_cnt),
    .perf_busy_cnt (perf_busy_cnt)
`endif
  );

  assign outVec = {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
                   id_ex_bubble, if_id_flush, id_ex_flush, stall_active};

  function automatic vec_t mk(input logic rstN, input logic memRead,
                              input logic [4:0] rd, input logic [4:0] rs1,
                              input logic u1, input logic [4:0] rs2,
                              input logic u2, input logic pc, input logic bz,
                              input logic [8:0] e);
    vec_t v;
    v.rstN = rstN; v.memRead = memRead; v.rd = rd; v.rs1 = rs1;
    v.rs1Used = u1; v.rs2 = rs2; v.rs2Used = u2; v.pcSel = pc; v.busy = bz;
    v.expOut = e;
    return v;
  endfunction

  // Quiet ID/EX (no load) and the canonical rd=5/rs1=5 load-use pattern.
  function automatic vec_t vNone(input logic pc, input logic bz, input logic [8:0] e);
    return mk(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, pc, bz, e);
  endfunction

  function automatic vec_t vHaz(input logic pc, input logic bz, input logic [8:0] e);
    return mk(1'b1, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, pc, bz, e);
  endfunction

  task automatic applyStimulus(input vec_t v);
    rst_n          = v.rstN;
    id_ex_mem_read = v.memRead;
    id_ex_rd       = v.rd;
    if_id_rs1      = v.rs1;
    rs1_used       = v.rs1Used;
    if_id_rs2      = v.rs2;
    rs2_used       = v.rs2Used;
    pc_sel         = v.pcSel;
    dmem_busy      = v.busy;
  endtask

  task automatic checkOutput(input string name, input int idx, input logic [8:0] expOut);
    vectors++;
    if (outVec !== expOut) begin
      miscompares++;
      $display("[TB] FAIL %s[%0d]: outputs got %b, expected %b", name, idx, outVec, expOut);
    end
  endtask

  // Reference model: counts remaining stall/flush cycles from the rules.
  task automatic modelStep(input vec_t v, output logic [8:0] expOut);
    bit haz;
    haz = v.memRead && (v.rd != 0) &&
          ((v.rs1Used && v.rd == v.rs1) || (v.rs2Used && v.rd == v.rs2));
    if (!v.rstN) begin
      expOut = O_RST; stallLeft = 0; flushLeft = 0;
    end else if (v.busy) begin
      expOut = O_BUSY;
    end else if (v.pcSel) begin
      expOut = O_BR; stallLeft = 0; flushLeft = FC - 1;
    end else if (flushLeft > 0) begin
      expOut = O_FL; flushLeft--;
    end else if (stallLeft > 0) begin
      expOut = O_STALL; stallLeft--;
    end else if (haz) begin
      expOut = O_STALL; stallLeft = LL - 1;
    end else begin
      expOut = O_DEF;
    end
  endtask

  initial begin
    vec_t v;
    logic [8:0] e;

    // Reset, source-operand filtering, a full 3-cycle stall.
    vecs.push_back(mk(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_RST));
    vecs.push_back(vNone(1'b0, 1'b0, O_DEF));
    vecs.push_back(mk(1'b1, 1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, O_DEF));
    vecs.push_back(mk(1'b1, 1'b1, 5'd7, 5'd3, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, O_DEF));
    vecs.push_back(mk(1'b1, 1'b1, 5'd7, 5'd3, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, O_STALL));
    vecs.push_back(vNone(1'b0, 1'b0, O_STALL));
    vecs.push_back(vNone(1'b0, 1'b0, O_STALL));
    vecs.push_back(vNone(1'b0, 1'b0, O_DEF));
    // Redirect aborts stall in its 2nd cycle; hazard during FLUSH ignored.
    vecs.push_back(vHaz(1'b0, 1'b0, O_STALL));
    vecs.push_back(vNone(1'b1, 1'b0, O_BR));
    vecs.push_back(vHaz(1'b0, 1'b0, O_FL));
    vecs.push_back(vNone(1'b0, 1'b0, O_DEF));
    // Busy freezes a stall for 4 cycles (pc_sel ignored), then it completes.
    vecs.push_back(vHaz(1'b0, 1'b0, O_STALL));
    vecs.push_back(vNone(1'b0, 1'b1, O_BUSY));
    vecs.push_back(vNone(1'b0, 1'b1, O_BUSY));
    vecs.push_back(vNone(1'b1, 1'b1, O_BUSY));
    vecs.push_back(vNone(1'b0, 1'b1, O_BUSY));
    vecs.push_back(vNone(1'b0, 1'b0, O_STALL));
    vecs.push_back(vNone(1'b0, 1'b0, O_STALL));
    vecs.push_back(vNone(1'b0, 1'b0, O_DEF));
    // Back-to-back hazards re-evaluate right after LD_STALL exits.
    vecs.push_back(vHaz(1'b0, 1'b0, O_STALL));
    vecs.push_back(vHaz(1'b0, 1'b0, O_STALL));
    vecs.push_back(vHaz(1'b0, 1'b0, O_STALL));
    vecs.push_back(vHaz(1'b0, 1'b0, O_STALL));
    vecs.push_back(vNone(1'b0, 1'b0, O_STALL));
    vecs.push_back(vNone(1'b0, 1'b0, O_STALL));
    vecs.push_back(vNone(1'b0, 1'b0, O_DEF));
    // Two-cycle flush, then the same with busy in the middle.
    vecs.push_back(vNone(1'b1, 1'b0, O_BR));
    vecs.push_back(vNone(1'b0, 1'b0, O_FL));
    vecs.push_back(vNone(1'b0, 1'b0, O_DEF));
    vecs.push_back(vNone(1'b1, 1'b0, O_BR));
    vecs.push_back(vNone(1'b0, 1'b1, O_BUSY));
    vecs.push_back(vNone(1'b0, 1'b0, O_FL));
    vecs.push_back(vNone(1'b0, 1'b0, O_DEF));
    // Reset during FLUSH returns to IDLE.
    vecs.push_back(vNone(1'b1, 1'b0, O_BR));
    vecs.push_back(mk(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_RST));
    vecs.push_back(vNone(1'b0, 1'b0, O_DEF));

    $display("[TB] directed table: %0d vectors", vecs.size());
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput("vec", i, vecs[i].expOut);
      @(posedge clk);
      #1;
    end

    // Randomized traffic, model synchronised by a leading reset cycle.
    $display("[TB] random phase");
    for (int n = 0; n < 2000; n++) begin
      v.rstN    = (n == 0) ? 1'b0 : ($urandom_range(0, 59) != 0);
      v.memRead = $urandom_range(0, 1) != 0;
      v.rd      = 5'($urandom_range(0, 3));
      v.rs1     = 5'($urandom_range(0, 3));
      v.rs2     = 5'($urandom_range(0, 3));
      v.rs1Used = $urandom_range(0, 3) != 0;
      v.rs2Used = $urandom_range(0, 1) != 0;
      v.pcSel   = $urandom_range(0, 9) == 0;
      v.busy    = $urandom_range(0, 6) == 0;
      modelStep(v, e);
      v.expOut = e;
      applyStimulus(v);
      #1;
      checkOutput("rand", n, e);
      @(posedge clk);
      #1;
    end

`ifdef HAZARD_PERF_CNT_EN
    // Counters read zero once reset has been sampled.
    applyStimulus(mk(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, O_RST));
    @(posedge clk);
    #1;
    vectors++;
    if (perf_stall_cnt !== 32'd0 || perf_flush_cnt !== 32'd0 || perf_busy_cnt !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL perf_reset: got %0d/%0d/%0d, expected 0/0/0",
               perf_stall_cnt, perf_flush_cnt, perf_busy_cnt);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
